ivi_scan_ctrl: RTL and testbench
================================

Name: ivi_scan_ctrl

Overview:
Sequencer for the time-interval measurement core. On a start request it steps through the enabled regimes in a fixed order: duration 3'b011, then period 3'b101, then delay 3'b110. For each regime it arms the core by pulsing access low, waits for end-of-measurement or a timeout, and latches the 9-digit BCD result with a one-cycle valid strobe. It sits between the host/display logic and the measurement core and is the only driver of the core's regime and access inputs.

Parameters:
TIMEOUT_CYCLES, 200000, maximum cycles in RUN before a timeout is declared (1 ms at 200 MHz); legal range 2..2^24-1.
ARM_CYCLES, 4, cycles meas_access is held low per arm; legal range 2..15.

Ports:
clk_200MHz  in  1  system clock
reset  in  1  synchronous, active-low
start  in  1  one-cycle scan request; ignored while busy=1 or when regime_mask=0
continuous  in  1  1 = restart the scan automatically after scan_done
abort  in  1  stop the current scan immediately
regime_mask  in  3  bit0 duration, bit1 period, bit2 delay
meas_end  in  1  end_measurement from the core
meas_digits  in  45  core outputs {mil_100..n_001}, 5 bits each, mil_100 in the MSBs
meas_access  out  1  core access (0 = clear/arm)
meas_regime  out  3  core regime select
busy  out  1  high in every state except IDLE
result_valid  out  1  one-cycle strobe
result_regime  out  3  regime code of the current result
result_digits  out  45  latched BCD result
result_timeout  out  1  result was produced by a timeout
scan_done  out  1  one-cycle strobe after the last enabled regime
timeout_count  out  8  count of timeouts, saturates at 255

Behaviour:
- Reset (reset=0 at a clock edge) puts the block in IDLE with: meas_access=1, meas_regime=3'b011, busy=0, result_valid=0, result_regime=0, result_digits=0, result_timeout=0, scan_done=0, timeout_count=0.
- Priority: reset, then abort, then all other conditions.
- States: IDLE, SELECT, ARM, RUN, CAPTURE, DONE.
- IDLE: when start=1 and regime_mask!=0, latch regime_mask into mask_q, set idx=0, go to SELECT. A start with regime_mask=0 is ignored.
- SELECT (1 cycle):
  - Take the lowest set bit of mask_q at position >= idx. Drive meas_regime to its code and set idx to that bit, then go to ARM.
  - If no such bit exists, go to DONE.
- ARM: meas_access=0 for exactly ARM_CYCLES cycles, then RUN. meas_regime is held stable from SELECT until the next SELECT.
- RUN:
  - meas_access=1; a 24-bit timer starts at 0 on entry.
  - If meas_end=1, go to CAPTURE and latch meas_digits into result_digits in that cycle.
  - Otherwise, if timer==TIMEOUT_CYCLES-1, go to CAPTURE with a timeout: result_digits=0, result_timeout=1, timeout_count increments (saturating at 255).
  - If meas_end and timeout occur in the same cycle, meas_end wins.
- CAPTURE (1 cycle): result_valid=1, result_regime=meas_regime; set idx=idx+1, then SELECT.
- DONE (1 cycle): scan_done=1.
  - If continuous=1, re-latch regime_mask into mask_q, set idx=0 and go to SELECT. If the new mask is 0, go to IDLE instead.
  - Otherwise go to IDLE.
- abort in any non-IDLE state: next state is IDLE and meas_access=1. No result_valid or scan_done is issued. result_* outputs hold their previous values.
- regime_mask changes in mid-scan have no effect; the mask is sampled only at start and at DONE.
- Latency:
  - start sampled at edge 0 gives meas_access low for edges 2..ARM_CYCLES+1.
  - meas_end sampled high in RUN gives result_valid on the next cycle.

Optional Feature:
IVI_SEQ_RETRY_EN:
- Defined: on the first timeout for a regime, the block returns to ARM for a single retry without asserting result_valid, and timeout_count is not incremented. A second timeout on the same regime is reported as normal. The retry flag clears at SELECT.
- Undefined: every timeout is reported immediately.

Test Plan:
1. regime_mask=3'b111, start pulse; bench core raises meas_end 50 cycles after access rises, digits=45'h0_0012_3456 -> three result_valid strobes with result_regime 011, 101, 110, each with those digits; then scan_done=1 for one cycle and busy=0.
2. regime_mask=3'b100, TIMEOUT_CYCLES=100, core never raises meas_end -> meas_regime=110; result_valid with result_timeout=1 and result_digits=0 exactly 100 cycles after RUN entry; timeout_count=1.
3. continuous=1, regime_mask=3'b001, then continuous=0 after the third scan_done -> exactly four scan_done pulses, then IDLE.
4. abort two cycles into RUN of period -> next cycle IDLE with meas_access=1; no result_valid or scan_done; a new start works normally.
5. meas_end rises in the same cycle the timer reaches TIMEOUT_CYCLES-1 -> result_timeout=0 and digits captured; start pulses while busy=1 are ignored; a start with regime_mask=0 keeps busy=0.
6. With IVI_SEQ_RETRY_EN defined: first arm times out and the second succeeds -> one result_valid with result_timeout=0, timeout_count=0, and two low meas_access windows.

Source files
------------

// File: rtl/ivi_scan_ctrl.sv
// rtl/ivi_scan_ctrl.sv - regime scan sequencer for the time-interval measurement core
// Optional: define IVI_SEQ_RETRY_EN to re-arm once on a regime's first timeout before reporting it.
module ivi_scan_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 200000,
   parameter int unsigned ARM_CYCLES     = 4
) (
   input  logic        clk_200MHz,
   input  logic        reset,
   input  logic        start,
   input  logic        continuous,
   input  logic        abort,
   input  logic [2:0]  regime_mask,
   input  logic        meas_end,
   input  logic [44:0] meas_digits,
   output logic        meas_access,
   output logic [2:0]  meas_regime,
   output logic        busy,
   output logic        result_valid,
   output logic [2:0]  result_regime,
   output logic [44:0] result_digits,
   output logic        result_timeout,
   output logic        scan_done,
   output logic [7:0]  timeout_count
);

   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ARM, S_RUN, S_CAPTURE, S_DONE} state_t;

   localparam logic [23:0] TIMER_LAST = 24'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  ARM_LAST   = 4'(ARM_CYCLES - 1);

   state_t      state_q, state_d;
   logic [2:0]  mask_q, mask_d;
   logic [1:0]  idx_q, idx_d;
   logic [2:0]  regime_q, regime_d;
   logic [3:0]  arm_cnt_q, arm_cnt_d;
   logic [23:0] timer_q, timer_d;
   logic [2:0]  res_regime_q, res_regime_d;
   logic [44:0] res_digits_q, res_digits_d;
   logic        res_timeout_q, res_timeout_d;
   logic [7:0]  tmo_cnt_q, tmo_cnt_d;
`ifdef IVI_SEQ_RETRY_EN
   logic        retry_q, retry_d;
`endif

   logic        sel_found;
   logic [1:0]  sel_idx;
   logic        do_retry;

   function automatic logic [2:0] regime_code(input logic [1:0] bit_pos);
      case (bit_pos)
         2'd0:    regime_code = 3'b011;
         2'd1:    regime_code = 3'b101;
         default: regime_code = 3'b110;
      endcase
   endfunction

   // Descending scan so the lowest qualifying bit is the one left standing.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         if (mask_q[i] && (2'(i) >= idx_q)) begin
            sel_found = 1'b1;
            sel_idx   = 2'(i);
         end
      end
   end

   always_comb begin
`ifdef IVI_SEQ_RETRY_EN
      do_retry = !retry_q;
`else
      do_retry = 1'b0;
`endif
   end

   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      idx_d         = idx_q;
      regime_d      = regime_q;
      arm_cnt_d     = arm_cnt_q;
      timer_d       = timer_q;
      res_regime_d  = res_regime_q;
      res_digits_d  = res_digits_q;
      res_timeout_d = res_timeout_q;
      tmo_cnt_d     = tmo_cnt_q;
`ifdef IVI_SEQ_RETRY_EN
      retry_d       = retry_q;
`endif
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && (regime_mask != 3'b000)) begin
                  mask_d  = regime_mask;
                  idx_d   = 2'd0;
                  state_d = S_SELECT;
               end
            end
            S_SELECT: begin
`ifdef IVI_SEQ_RETRY_EN
               retry_d = 1'b0;
`endif
               if (sel_found) begin
                  regime_d  = regime_code(sel_idx);
                  idx_d     = sel_idx;
                  arm_cnt_d = 4'd0;
                  state_d   = S_ARM;
               end else begin
                  state_d = S_DONE;
               end
            end
            S_ARM: begin
               if (arm_cnt_q == ARM_LAST) begin
                  timer_d = 24'd0;
                  state_d = S_RUN;
               end else begin
                  arm_cnt_d = arm_cnt_q + 4'd1;
               end
            end
            S_RUN: begin
               if (meas_end) begin
                  res_digits_d  = meas_digits;
                  res_timeout_d = 1'b0;
                  res_regime_d  = regime_q;
                  state_d       = S_CAPTURE;
               end else if (timer_q == TIMER_LAST) begin
                  if (do_retry) begin
`ifdef IVI_SEQ_RETRY_EN
                     retry_d = 1'b1;
`endif
                     arm_cnt_d = 4'd0;
                     state_d   = S_ARM;
                  end else begin
                     res_digits_d  = 45'd0;
                     res_timeout_d = 1'b1;
                     res_regime_d  = regime_q;
                     if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
                     state_d = S_CAPTURE;
                  end
               end else begin
                  timer_d = timer_q + 24'd1;
               end
            end
            S_CAPTURE: begin
               idx_d   = idx_q + 2'd1;
               state_d = S_SELECT;
            end
            S_DONE: begin
               if (continuous) begin
                  mask_d  = regime_mask;
                  idx_d   = 2'd0;
                  state_d = (regime_mask != 3'b000) ? S_SELECT : S_IDLE;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_200MHz) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         mask_q        <= 3'b000;
         idx_q         <= 2'd0;
         regime_q      <= 3'b011;
         arm_cnt_q     <= 4'd0;
         timer_q       <= 24'd0;
         res_regime_q  <= 3'b000;
         res_digits_q  <= 45'd0;
         res_timeout_q <= 1'b0;
         tmo_cnt_q     <= 8'd0;
`ifdef IVI_SEQ_RETRY_EN
         retry_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         mask_q        <= mask_d;
         idx_q         <= idx_d;
         regime_q      <= regime_d;
         arm_cnt_q     <= arm_cnt_d;
         timer_q       <= timer_d;
         res_regime_q  <= res_regime_d;
         res_digits_q  <= res_digits_d;
         res_timeout_q <= res_timeout_d;
         tmo_cnt_q     <= tmo_cnt_d;
`ifdef IVI_SEQ_RETRY_EN
         retry_q       <= retry_d;
`endif
      end
   end

   assign meas_access    = (state_q != S_ARM);
   assign meas_regime    = regime_q;
   assign busy           = (state_q != S_IDLE);
   assign result_valid   = (state_q == S_CAPTURE);
   assign result_regime  = res_regime_q;
   assign result_digits  = res_digits_q;
   assign result_timeout = res_timeout_q;
   assign scan_done      = (state_q == S_DONE);
   assign timeout_count  = tmo_cnt_q;

endmodule

// File: tb/tb_ivi_scan_ctrl.sv
// tb/tb_ivi_scan_ctrl.sv - scoreboard bench for ivi_scan_ctrl with a behavioural measurement core
// Optional: define IVI_SEQ_RETRY_EN to build and check the retry variant.
module tb_ivi_scan_ctrl;

   localparam int TMO = 100;
   localparam int ARM = 4;

   logic        clk_200MHz = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic        abort = 1'b0;
   logic [2:0]  regime_mask = 3'b000;
   logic        meas_end = 1'b0;
   logic [44:0] meas_digits = 45'd0;
   logic        meas_access;
   logic [2:0]  meas_regime;
   logic        busy;
   logic        result_valid;
   logic [2:0]  result_regime;
   logic [44:0] result_digits;
   logic        result_timeout;
   logic        scan_done;
   logic [7:0]  timeout_count;

   ivi_scan_ctrl #(.TIMEOUT_CYCLES(TMO), .ARM_CYCLES(ARM)) dut (
      .clk_200MHz(clk_200MHz), .reset(reset), .start(start), .continuous(continuous),
      .abort(abort), .regime_mask(regime_mask), .meas_end(meas_end), .meas_digits(meas_digits),
      .meas_access(meas_access), .meas_regime(meas_regime), .busy(busy),
      .result_valid(result_valid), .result_regime(result_regime), .result_digits(result_digits),
      .result_timeout(result_timeout), .scan_done(scan_done), .timeout_count(timeout_count)
   );

   always #5 clk_200MHz = ~clk_200MHz;

   typedef struct {
      logic [2:0]  regime;
      logic [44:0] digits;
      logic        tmo;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   end_delay = 0, skip_arms = 0, core_cnt = 0, low_len = 0;
   int   rise_cyc = 0, n_windows = 0, first_low = 0, n_results = 0, n_done = 0;
   int   st_cyc = 0;
   bit   capture_first = 1'b0, prev_acc = 1'b1, core_armed = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic expect_res(input logic [2:0] r, input logic [44:0] d, input logic t, input int lat);
      exp_t e;
      e.regime = r; e.digits = d; e.tmo = t; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk_200MHz);
      #1;
   endtask

   task automatic start_pulse(input logic [2:0] m);
      regime_mask = m;
      start = 1'b1;
      st_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int bound, input string tag);
      for (int i = 0; i < bound && busy; i++) tick();
      chk({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) tick();
   endtask

   always @(posedge clk_200MHz) cyc <= cyc + 1;

   // Core model: meas_end pulses so it is sampled end_delay edges after RUN entry.
   always @(negedge clk_200MHz) begin
      if (!meas_access) begin
         if (prev_acc) begin
            n_windows++;
            low_len = 0;
            if (capture_first) begin
               first_low = cyc;
               capture_first = 1'b0;
            end
         end
         low_len++;
         meas_end = 1'b0;
         core_armed = 1'b0;
      end else if (!prev_acc) begin
         chk("arm_len", 64'(low_len), 64'(ARM));
         rise_cyc = cyc;
         core_cnt = 0;
         if (skip_arms > 0) begin
            skip_arms--;
            core_armed = 1'b0;
         end else begin
            core_armed = (end_delay > 0);
         end
         meas_end = core_armed && (end_delay == 1);
      end else begin
         core_cnt++;
         meas_end = core_armed && (core_cnt == end_delay - 1);
      end
      prev_acc = meas_access;
   end

   always @(negedge clk_200MHz) begin
      if (reset && result_valid) begin
         n_results++;
         if (sb.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_regime", 64'(result_regime), 64'(e.regime));
            chk("res_digits", 64'(result_digits), 64'(e.digits));
            chk("res_timeout", 64'(result_timeout), 64'(e.tmo));
            chk("res_latency", 64'(cyc - rise_cyc), 64'(e.lat));
         end
      end
      if (reset && scan_done) n_done++;
   end

   initial begin
      int d0, w0, r0, i;
      logic [44:0] d1, d5;
      d1 = 45'h0_0012_3456;
      d5 = 45'h1_2345_6789;

      do_reset();
      chk("rst_access", 64'(meas_access), 64'd1);
      chk("rst_regime", 64'(meas_regime), 64'b011);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(result_valid), 64'd0);
      chk("rst_res_regime", 64'(result_regime), 64'd0);
      chk("rst_res_digits", 64'(result_digits), 64'd0);
      chk("rst_res_timeout", 64'(result_timeout), 64'd0);
      chk("rst_done", 64'(scan_done), 64'd0);
      chk("rst_tmo_cnt", 64'(timeout_count), 64'd0);
      reset = 1'b1;
      tick();

      // Full three-regime scan.
      meas_digits = d1;
      end_delay = 50;
      capture_first = 1'b1;
      expect_res(3'b011, d1, 1'b0, 50);
      expect_res(3'b101, d1, 1'b0, 50);
      expect_res(3'b110, d1, 1'b0, 50);
      d0 = n_done;
      start_pulse(3'b111);
      wait_idle(2000, "t1");
      chk("t1_start_to_arm", 64'(first_low - st_cyc), 64'd2);
      chk("t1_done", 64'(n_done - d0), 64'd1);
      chk("t1_sb_empty", 64'(sb.size()), 64'd0);

      // Delay-only timeout.
      end_delay = 0;
      w0 = n_windows;
      expect_res(3'b110, 45'd0, 1'b1, TMO);
      start_pulse(3'b100);
      wait_idle(2000, "t2");
      chk("t2_regime", 64'(meas_regime), 64'b110);
      chk("t2_tmo_cnt", 64'(timeout_count), 64'd1);
`ifdef IVI_SEQ_RETRY_EN
      chk("t2_windows", 64'(n_windows - w0), 64'd2);
`else
      chk("t2_windows", 64'(n_windows - w0), 64'd1);
`endif
      chk("t2_sb_empty", 64'(sb.size()), 64'd0);

      // Continuous mode: drop continuous during the fourth scan.
      end_delay = 10;
      continuous = 1'b1;
      d0 = n_done;
      for (int k = 0; k < 4; k++) expect_res(3'b011, d1, 1'b0, 10);
      start_pulse(3'b001);
      for (i = 0; i < 1000 && (n_done - d0) < 3; i++) tick();
      chk("t3_third_done_seen", 64'(n_done - d0), 64'd3);
      tick();
      continuous = 1'b0;
      wait_idle(1000, "t3");
      chk("t3_done", 64'(n_done - d0), 64'd4);
      chk("t3_sb_empty", 64'(sb.size()), 64'd0);

      // Abort two cycles into the period RUN.
      end_delay = 50;
      expect_res(3'b011, d1, 1'b0, 50);
      r0 = n_results;
      d0 = n_done;
      start_pulse(3'b011);
      for (i = 0; i < 1000 && !(meas_regime == 3'b101 && !meas_access); i++) tick();
      for (i = 0; i < 20 && !meas_access; i++) tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_access", 64'(meas_access), 64'd1);
      repeat (80) tick();
      chk("t4_results", 64'(n_results - r0), 64'd1);
      chk("t4_done", 64'(n_done - d0), 64'd0);
      chk("t4_res_regime_held", 64'(result_regime), 64'b011);
      chk("t4_sb_empty", 64'(sb.size()), 64'd0);
      end_delay = 20;
      expect_res(3'b101, d1, 1'b0, 20);
      start_pulse(3'b010);
      wait_idle(1000, "t4b");
      chk("t4b_done", 64'(n_done - d0), 64'd1);
      chk("t4b_sb_empty", 64'(sb.size()), 64'd0);

      // meas_end on the timeout cycle; ignored starts.
      meas_digits = d5;
      end_delay = TMO;
      expect_res(3'b011, d5, 1'b0, TMO);
      start_pulse(3'b001);
      tick();
      tick();
      start_pulse(3'b111);
      wait_idle(1000, "t5");
      chk("t5_tmo_cnt", 64'(timeout_count), 64'd1);
      chk("t5_sb_empty", 64'(sb.size()), 64'd0);
      start_pulse(3'b000);
      tick();
      chk("t5_zero_mask_busy", 64'(busy), 64'd0);

`ifdef IVI_SEQ_RETRY_EN
      // First arm times out, retry succeeds.
      do_reset();
      reset = 1'b1;
      tick();
      skip_arms = 1;
      end_delay = 30;
      w0 = n_windows;
      r0 = n_results;
      expect_res(3'b011, d5, 1'b0, 30);
      start_pulse(3'b001);
      wait_idle(2000, "t6");
      chk("t6_windows", 64'(n_windows - w0), 64'd2);
      chk("t6_results", 64'(n_results - r0), 64'd1);
      chk("t6_tmo_cnt", 64'(timeout_count), 64'd0);
      chk("t6_sb_empty", 64'(sb.size()), 64'd0);
`endif

      repeat (5) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got cycle %0d expected completion", cyc);
      $fatal(1);
   end

endmodule
